lsu_rv32i: RTL and testbench

Load/store unit between the RV32I core's execute stage and the byte-enabled data memory. The data memory has a 1-cycle synchronous read.
- Accepts one memory request at a time over a valid/ready handshake.
- Checks alignment, legality and range, then drives the memory port for exactly one cycle.
- Waits out the read latency, then extracts, aligns and sign- or zero-extends load data.
- Returns a one-cycle response with error flags. Faulting requests never touch memory.

---
 rtl/lsu_rv32i_if.sv | 40 ++++
 rtl/lsu_rv32i.sv | 196 +++++++++++++++++++
 tb/tb_lsu_rv32i.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_rv32i_if.sv
// Core/memory-facing bundle of the load/store unit.
// The LSU takes the slave view; the core plus data memory take the master view.
interface lsu_rv32i_if;
  // Core request
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  // Core response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;

  // Data memory port
  logic        mem_store;
  logic [1:0]  mem_storetype;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_misaligned, resp_fault,
    output mem_store, mem_storetype, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_misaligned, resp_fault,
    input  mem_store, mem_storetype, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit: one request at a time, alignment/legality/range
// checks, single-cycle memory access, load extraction and extension.
module lsu_rv32i #(
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  lsu_rv32i_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;

  // Latched request fields still needed after the handshake.
  // Store data and address go straight into the memory-port registers.
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  // Registered outputs
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_mis_q;
  logic        resp_fault_q;
  logic        mem_store_q;
  logic [1:0]  mem_storetype_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  // Request checks, evaluated from the live request inputs
  logic [2:0]  size_c;
  logic [32:0] end_c;
  logic        legal_c;
  logic        range_c;
  logic        mis_c;
  logic        fault_c;

  // Load data path
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] load_c;

  // Classify the incoming request: access size, legality, range, alignment.
  always_comb begin
    size_c  = 3'd4;
    legal_c = 1'b0;
    mis_c   = 1'b0;

    unique case (bus.req_funct3[1:0])
      2'b00:   size_c = 3'd1;
      2'b01:   size_c = 3'd2;
      default: size_c = 3'd4;
    endcase

    if (bus.req_store) begin
      legal_c = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                (bus.req_funct3 == 3'b010);
    end else begin
      legal_c = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                (bus.req_funct3 == 3'b101);
    end

    // Compare the last byte touched (+1) against the memory size in 33 bits
    // so addresses near 2^32 cannot wrap into range.
    end_c   = {1'b0, bus.req_addr} + 33'(size_c);
    range_c = end_c > 33'(DMEM_BYTES);

    if (bus.req_funct3[1:0] == 2'b01) begin
      mis_c = bus.req_addr[0];
    end else if (bus.req_funct3[1:0] == 2'b10) begin
      mis_c = (bus.req_addr[1:0] != 2'b00);
    end

    fault_c = !legal_c || range_c;
  end

  // Select the addressed byte/half of the read word and extend it.
  always_comb begin
    byte_c = bus.mem_rdata[7:0];
    unique case (off_q)
      2'd0: byte_c = bus.mem_rdata[7:0];
      2'd1: byte_c = bus.mem_rdata[15:8];
      2'd2: byte_c = bus.mem_rdata[23:16];
      2'd3: byte_c = bus.mem_rdata[31:24];
    endcase

    half_c = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    unique case (funct3_q)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  load_c = {24'h000000, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b101:  load_c = {16'h0000, half_c};
      default: load_c = bus.mem_rdata;
    endcase
  end

  // Request sequencer: IDLE -> (ACCESS -> [WAIT] ->) RESP -> IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      store_q         <= 1'b0;
      funct3_q        <= '0;
      off_q           <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_mis_q      <= 1'b0;
      resp_fault_q    <= 1'b0;
      mem_store_q     <= 1'b0;
      mem_storetype_q <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            store_q     <= bus.req_store;
            funct3_q    <= bus.req_funct3;
            off_q       <= bus.req_addr[1:0];
            if (fault_c || mis_c) begin
              // Faulting requests go straight to the response; the memory
              // port registers are left untouched.
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_fault_q <= fault_c;
              resp_mis_q   <= mis_c && !fault_c;
            end else begin
              state_q         <= S_ACCESS;
              mem_addr_q      <= bus.req_addr;
              mem_wdata_q     <= bus.req_wdata;
              mem_storetype_q <= bus.req_funct3[1:0];
              mem_store_q     <= bus.req_store;
            end
          end
        end

        S_ACCESS: begin
          mem_store_q <= 1'b0;
          if (store_q) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            resp_fault_q <= 1'b0;
          end else begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_c;
          resp_mis_q   <= 1'b0;
          resp_fault_q <= 1'b0;
        end

        S_RESP: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_mis_q   <= 1'b0;
          resp_fault_q <= 1'b0;
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready       = req_ready_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.resp_misaligned = resp_mis_q;
  assign bus.resp_fault      = resp_fault_q;
  assign bus.mem_store       = mem_store_q;
  assign bus.mem_storetype   = mem_storetype_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_lsu_rv32i.sv
// Directed bench for lsu_rv32i with a byte-lane data memory model
// (1-cycle synchronous read, lane alignment done in the memory).
module tb_lsu_rv32i;

  logic clock;
  logic reset_n;

  int n_checks;
  int n_errors;

  lsu_rv32i_if bus ();

  lsu_rv32i #(.DMEM_BYTES(1024)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory model
  logic [7:0] mem [0:1023];
  logic [9:0] wa;
  assign wa = {bus.mem_addr[9:2], 2'b00};

  always @(posedge clock) begin
    bus.mem_rdata <= {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]};
    if (bus.mem_store) begin
      case (bus.mem_storetype)
        2'b00: mem[bus.mem_addr[9:0]] <= bus.mem_wdata[7:0];
        2'b01: begin
          mem[{bus.mem_addr[9:1], 1'b0}]       <= bus.mem_wdata[7:0];
          mem[{bus.mem_addr[9:1], 1'b0} + 10'd1] <= bus.mem_wdata[15:8];
        end
        default: begin
          mem[wa]         <= bus.mem_wdata[7:0];
          mem[wa + 10'd1] <= bus.mem_wdata[15:8];
          mem[wa + 10'd2] <= bus.mem_wdata[23:16];
          mem[wa + 10'd3] <= bus.mem_wdata[31:24];
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request: waits for ready, handshakes, measures latency, checks
  // response contents, mem_store activity and the return to IDLE.
  task automatic txn(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int exp_lat, input logic [31:0] exp_rdata,
                     input logic exp_mis, input logic exp_fault);
    int lat;
    int stcnt;
    int st_at;
    logic [31:0] rd;
    logic mis, flt;
    int w;
    lat = 0; stcnt = 0; st_at = 0; rd = 'x; mis = 1'bx; flt = 1'bx;
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clock);
      if (bus.mem_store) begin
        stcnt++;
        st_at = c;
      end
      if (bus.resp_valid) begin
        lat = c;
        rd  = bus.resp_rdata;
        mis = bus.resp_misaligned;
        flt = bus.resp_fault;
        break;
      end
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".rdata"}, rd, exp_rdata);
    check({tag, ".flags"}, {30'd0, mis, flt}, {30'd0, exp_mis, exp_fault});
    check({tag, ".stcnt"}, 32'(stcnt), (st && exp_lat == 2) ? 32'd1 : 32'd0);
    check({tag, ".st_at"}, 32'(st_at), (st && exp_lat == 2) ? 32'd1 : 32'd0);
    @(negedge clock);
    check({tag, ".post"}, {bus.resp_valid, bus.req_ready, bus.resp_misaligned, bus.resp_fault, bus.mem_store, bus.resp_rdata[26:0]},
          {5'b01000, 27'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0]  rdy_v;
  logic [7:0]  rsp_v;
  logic [31:0] d3, d7;

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    reset_n = 1'b0;
    #12;
    check("rst.ready", 32'(bus.req_ready), 32'd1);
    check("rst.ctl", {28'd0, bus.resp_valid, bus.resp_misaligned, bus.resp_fault, bus.mem_store}, 32'd0);
    check("rst.rdata", bus.resp_rdata, 32'd0);
    check("rst.maddr", bus.mem_addr, 32'd0);
    check("rst.mwdata", bus.mem_wdata, 32'd0);
    check("rst.mtype", 32'(bus.mem_storetype), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Store then word load
    txn("sw10",  1'b1, 3'b010, 32'h10, 32'h8899AABB, 2, 32'h0, 1'b0, 1'b0);
    check("sw10.mtype", 32'(bus.mem_storetype), 32'd2);
    check("sw10.maddr", bus.mem_addr, 32'h10);
    txn("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h8899AABB, 1'b0, 1'b0);

    // Sub-word loads
    txn("lb11",  1'b0, 3'b000, 32'h11, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 1'b0);
    txn("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 3, 32'h000000AA, 1'b0, 1'b0);
    txn("lh12",  1'b0, 3'b001, 32'h12, 32'h0, 3, 32'hFFFF8899, 1'b0, 1'b0);
    txn("lhu12", 1'b0, 3'b101, 32'h12, 32'h0, 3, 32'h00008899, 1'b0, 1'b0);
    txn("lb10",  1'b0, 3'b000, 32'h10, 32'h0, 3, 32'hFFFFFFBB, 1'b0, 1'b0);
    txn("lh10",  1'b0, 3'b001, 32'h10, 32'h0, 3, 32'hFFFFAABB, 1'b0, 1'b0);
    txn("lbu12", 1'b0, 3'b100, 32'h12, 32'h0, 3, 32'h00000099, 1'b0, 1'b0);

    // Sub-word stores (upper wdata bits are junk the memory must ignore)
    txn("sb13",  1'b1, 3'b000, 32'h13, 32'hFFFFFF5A, 2, 32'h0, 1'b0, 1'b0);
    check("sb13.mwdata", bus.mem_wdata, 32'hFFFFFF5A);
    txn("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h5A99AABB, 1'b0, 1'b0);
    txn("sh10",  1'b1, 3'b001, 32'h10, 32'h00001234, 2, 32'h0, 1'b0, 1'b0);
    txn("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h5A991234, 1'b0, 1'b0);

    // Misaligned: no memory activity, memory unchanged
    txn("lw12m", 1'b0, 3'b010, 32'h12, 32'h0, 1, 32'h0, 1'b1, 1'b0);
    txn("sh11m", 1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 1'b0);
    check("sh11m.maddr", bus.mem_addr, 32'h10);
    txn("lw10d", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h5A991234, 1'b0, 1'b0);

    // Range and legality at the top of memory
    txn("sw3fc", 1'b1, 3'b010, 32'h3FC, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1'b0);
    txn("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0);
    txn("lb3ff", 1'b0, 3'b000, 32'h3FF, 32'h0, 3, 32'hFFFFFFDE, 1'b0, 1'b0);
    txn("lhu3fe",1'b0, 3'b101, 32'h3FE, 32'h0, 3, 32'h0000DEAD, 1'b0, 1'b0);
    txn("lw400", 1'b0, 3'b010, 32'h400, 32'h0, 1, 32'h0, 1'b0, 1'b1);
    txn("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b0, 1'b1);
    txn("lh401", 1'b0, 3'b001, 32'h401, 32'h0, 1, 32'h0, 1'b0, 1'b1);
    txn("lh3ff", 1'b0, 3'b001, 32'h3FF, 32'h0, 1, 32'h0, 1'b0, 1'b1);
    txn("st011", 1'b1, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b0, 1'b1);
    txn("st100", 1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b0, 1'b1);
    txn("sw400", 1'b1, 3'b010, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1'b0, 1'b1);
    txn("lw10e", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h5A991234, 1'b0, 1'b0);

    // Back-to-back loads with req_valid held high
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    d3 = '0; d7 = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      rdy_v[i-1] = bus.req_ready;
      rsp_v[i-1] = bus.resp_valid;
      if (i == 3) d3 = bus.resp_rdata;
      if (i == 7) begin
        d7 = bus.resp_rdata;
        bus.req_valid = 1'b0;
      end
    end
    check("b2b.ready", 32'(rdy_v), 32'b1000_1000);
    check("b2b.resp",  32'(rsp_v), 32'b0100_0100);
    check("b2b.d3", d3, 32'h5A991234);
    check("b2b.d7", d7, 32'h5A991234);

    // Reset during WAIT: request dropped, outputs cleared immediately
    @(negedge clock);
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rw.ready", 32'(bus.req_ready), 32'd1);
    check("rw.ctl", {28'd0, bus.resp_valid, bus.resp_misaligned, bus.resp_fault, bus.mem_store}, 32'd0);
    check("rw.maddr", bus.mem_addr, 32'd0);
    check("rw.out", bus.resp_rdata | bus.mem_wdata | 32'(bus.mem_storetype), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rsp_v = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      rsp_v[i] = bus.resp_valid;
    end
    check("rw.noresp", 32'(rsp_v), 32'd0);

    // Reset during ACCESS of a store: mem_store drops at once, no write
    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'hCAFEF00D;
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("ra.mstore", 32'(bus.mem_store), 32'd1);
    reset_n = 1'b0;
    #1;
    check("ra.mstore0", 32'(bus.mem_store), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    txn("lw10f", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'h5A991234, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
